// File: rtl/floo_pkg.sv
// Shared FlooNoC types and width helpers used by the link and router blocks.
package floo_pkg;

  typedef enum logic [1:0] {
    IdTable,
    SourceRouting,
    XYRouting
  } route_algo_e;

  // Widest VC tag a link may carry; per-link tags are sized with vc_id_w().
  localparam int unsigned MaxVcIdW = 4;
  typedef logic [MaxVcIdW-1:0] link_vc_id_t;

  function automatic int unsigned credit_cnt_w(input int unsigned num_credits);
    return $clog2(num_credits + 1);
  endfunction

  function automatic int unsigned vc_id_w(input int unsigned num_vcs);
    return (num_vcs > 1) ? $clog2(num_vcs) : 1;
  endfunction

endpackage

// File: rtl/floo_credit_counter.sv
// Per-VC credit counter: decrements on a grant, increments on a returned credit,
// saturates at NumCredits and flags protocol violations.
module floo_credit_counter
  import floo_pkg::*;
#(
  parameter int unsigned NumCredits = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic take_i,
  input  logic credit_i,
  output logic has_credit_o
);

  localparam int unsigned CntW = credit_cnt_w(NumCredits);
  localparam logic [CntW-1:0] CntMax = CntW'(NumCredits);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= CntMax;
    end else if (take_i && !credit_i) begin
      r_cnt <= r_cnt - CntW'(1);
    end else if (credit_i && !take_i && (r_cnt != CntMax)) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign has_credit_o = (r_cnt != '0);

  // A grant at zero or a credit beyond the receiver FIFO depth is a link protocol error.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(take_i && (r_cnt == '0)));
      assert (!(credit_i && !take_i && (r_cnt == CntMax)));
    end
  end

endmodule

// File: rtl/floo_credit_link_tx.sv
// Transmit side of a credit-based flit link: round-robin over VCs holding credits,
// one registered flit per cycle tagged with its VC.
module floo_credit_link_tx
  import floo_pkg::*;
#(
  parameter int unsigned NumVirtChannels = 1,
  parameter int unsigned NumCredits      = 2,
  parameter type         flit_t          = logic
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumVirtChannels-1:0]            valid_i,
  output logic [NumVirtChannels-1:0]            ready_o,
  input  flit_t [NumVirtChannels-1:0]           data_i,
  output logic                                  valid_o,
  output logic [vc_id_w(NumVirtChannels)-1:0]   vc_id_o,
  output flit_t                                 data_o,
  input  logic [NumVirtChannels-1:0]            credit_i,
  output logic [NumVirtChannels-1:0]            credit_o
);

  localparam int unsigned VcIdW = vc_id_w(NumVirtChannels);

  logic [NumVirtChannels-1:0] w_elig;
  logic [VcIdW-1:0]           w_cand;
  logic [VcIdW-1:0]           w_gnt_idx;
  logic                       w_gnt_vld;
  logic [VcIdW-1:0]           w_ptr_nxt;
  logic [VcIdW-1:0]           r_ptr;
  logic                       r_valid_p1;
  logic [VcIdW-1:0]           r_vc_p1;
  flit_t                      r_data_p1;

  for (genvar v = 0; v < NumVirtChannels; v++) begin : g_vc
    floo_credit_counter #(
      .NumCredits(NumCredits)
    ) i_credit_counter (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .take_i      (ready_o[v]),
      .credit_i    (credit_i[v]),
      .has_credit_o(credit_o[v])
    );

    assert property (@(posedge clk_i) disable iff (rst_i)
      (valid_i[v] && !ready_o[v]) |=> (!valid_i[v] || $stable(data_i[v])));
  end

  // Credits come from registered counters only, so a credit returned this cycle
  // becomes usable next cycle and ready_o has no path from credit_i.
  assign w_elig = valid_i & credit_o;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NumVirtChannels; k++) begin
      w_cand = VcIdW'((32'(r_ptr) + k) % NumVirtChannels);
      if (!w_gnt_vld && w_elig[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign ready_o   = (w_gnt_vld && !rst_i) ? (NumVirtChannels'(1) << w_gnt_idx) : '0;
  assign w_ptr_nxt = (32'(w_gnt_idx) == NumVirtChannels - 1) ? '0 : w_gnt_idx + VcIdW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_gnt_vld) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Stage p1: link output register; tag and payload hold when idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_p1 <= 1'b0;
      r_vc_p1    <= '0;
      r_data_p1  <= '0;
    end else begin
      r_valid_p1 <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_vc_p1   <= w_gnt_idx;
        r_data_p1 <= data_i[w_gnt_idx];
      end
    end
  end

  assign valid_o = r_valid_p1;
  assign vc_id_o = r_vc_p1;
  assign data_o  = r_data_p1;

  assert property (@(posedge clk_i) $onehot0(ready_o));

endmodule
